// File: rtl/riscvlong_mem_arbiter.sv
// Memory request arbiter: N requesters share one memory port, responses routed back in issue order.
// Define RISCVLONG_MEM_ARB_RR_EN for round-robin arbitration; default build is fixed priority (index 0 highest).
module riscvlong_mem_arbiter #(
    parameter int NREQ    = 2,
    parameter int REQ_SZ  = 67,
    parameter int RESP_SZ = 35,
    parameter int DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ*REQ_SZ-1:0]    req_msg,
    input  logic [NREQ-1:0]           req_val,
    output logic [NREQ-1:0]           req_rdy,
    output logic [REQ_SZ-1:0]         memreq_msg,
    output logic                      memreq_val,
    input  logic                      memreq_rdy,
    input  logic [RESP_SZ-1:0]        memresp_msg,
    input  logic                      memresp_val,
    output logic [RESP_SZ-1:0]        resp_msg,
    output logic [NREQ-1:0]           resp_val,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic                      protocol_err
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [IW-1:0] idx_t;

    idx_t            id_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            hold_q, hold_d;
    idx_t            hold_idx_q, hold_idx_d;
    idx_t            winner;
    logic            found;
    logic            not_full;
    logic            fire;
    logic            pop;
    logic            spurious;

`ifdef RISCVLONG_MEM_ARB_RR_EN
    idx_t            last_q, last_d;
    int              rr_cand;
`endif

    // A stalled grant is locked so the offered message cannot change under a waiting downstream.
    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        winner = '0;
        found  = 1'b0;
        if (hold_q && req_val[hold_idx_q]) begin
            winner = hold_idx_q;
            found  = 1'b1;
        end
`ifdef RISCVLONG_MEM_ARB_RR_EN
        rr_cand = 0;
        for (int k = 0; k < NREQ; k++) begin
            rr_cand = (int'(last_q) + 1 + k) % NREQ;
            if (!found && req_val[rr_cand]) begin
                winner = idx_t'(rr_cand);
                found  = 1'b1;
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_val[k]) begin
                winner = idx_t'(k);
                found  = 1'b1;
            end
        end
`endif
    end

    // Gating uses only the registered count, keeping memresp_val off the request path.
    assign not_full   = cnt_q < CW'(DEPTH);
    assign memreq_msg = req_msg[winner*REQ_SZ +: REQ_SZ];
    assign memreq_val = reset & (|req_val) & not_full;
    assign fire       = memreq_val & memreq_rdy;
    assign pop        = reset & memresp_val & (cnt_q != '0);
    assign spurious   = reset & memresp_val & (cnt_q == '0);
    assign resp_msg   = memresp_msg;
    assign outstanding  = cnt_q;
    assign protocol_err = err_q;

    always_comb begin
        req_rdy  = '0;
        resp_val = '0;
        if (fire) req_rdy[winner] = 1'b1;
        if (pop)  resp_val[id_mem[rd_ptr_q]] = 1'b1;
    end

    always_comb begin
        wr_ptr_d   = fire ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d      = cnt_q;
        if (fire && !pop) cnt_d = cnt_q + CW'(1);
        if (pop && !fire) cnt_d = cnt_q - CW'(1);
        err_d      = err_q | spurious;
        hold_d     = memreq_val & ~memreq_rdy;
        hold_idx_d = winner;
`ifdef RISCVLONG_MEM_ARB_RR_EN
        last_d     = fire ? winner : last_q;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
`ifdef RISCVLONG_MEM_ARB_RR_EN
            last_q     <= idx_t'(NREQ - 1);
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
`ifdef RISCVLONG_MEM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    // NOTE: the ID storage has no reset; entries are only read after being written, as guarded by the count.
    always_ff @(posedge clk) begin
        if (fire) id_mem[wr_ptr_q] <= winner;
    end

endmodule

// File: tb/tb_riscvlong_mem_arbiter.sv
// Directed bench for riscvlong_mem_arbiter (NREQ=2, DEPTH=4) with an in-order response scoreboard.
module tb_riscvlong_mem_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic [133:0]  req_msg;
    logic [1:0]    req_val;
    logic [1:0]    req_rdy;
    logic [66:0]   memreq_msg;
    logic          memreq_val;
    logic          memreq_rdy;
    logic [34:0]   memresp_msg;
    logic          memresp_val;
    logic [34:0]   resp_msg;
    logic [1:0]    resp_val;
    logic [2:0]    outstanding;
    logic          protocol_err;

    riscvlong_mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_msg      (req_msg),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .memreq_msg   (memreq_msg),
        .memreq_val   (memreq_val),
        .memreq_rdy   (memreq_rdy),
        .memresp_msg  (memresp_msg),
        .memresp_val  (memresp_val),
        .resp_msg     (resp_msg),
        .resp_val     (resp_val),
        .outstanding  (outstanding),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [34:0] msg;
    } sb_t;

    sb_t         sb[$];
    logic [34:0] mem_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          tag = 0;
    logic        exp_err = 1'b0;
    logic        exp_hold = 1'b0;
    int          exp_hold_idx = 0;
    int          exp_last = 1;
    logic [1:0]  last_rdy;
    logic [1:0]  last_resp;
    logic [1:0]  grant_seq [4];
    logic [1:0]  order_seq [3];

    function automatic logic [66:0] req_word(input int i, input int t);
        return {3'b101, 32'hFACE_0000 ^ 32'(t), 32'(t * 8 + i)};
    endfunction

    function automatic logic [34:0] rsp_of(input logic [66:0] m);
        return m[34:0] ^ 35'h4_0000_0001;
    endfunction

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock cycle starting at a negedge: drive, check combinational/registered outputs, advance model.
    task automatic cycle(input logic [1:0] rv, input logic mrdy, input logic rsp);
        logic [34:0] rm;
        int          w, p, sz;
        logic        ev, fire, pop;
        logic [1:0]  erdy, eresp;
        rm = 35'h2_DEAD_BEEF;
        if (rsp && reset && mem_q.size() > 0) rm = mem_q.pop_front();
        req_val     = rv;
        req_msg     = {req_word(1, tag), req_word(0, tag)};
        memreq_rdy  = mrdy;
        memresp_val = rsp;
        memresp_msg = rm;
        #1;
        if (exp_hold && rv[exp_hold_idx]) w = exp_hold_idx;
        else begin
`ifdef RISCVLONG_MEM_ARB_RR_EN
            p = (exp_last + 1) % 2;
            w = rv[p] ? p : 1 - p;
`else
            w = rv[0] ? 0 : 1;
`endif
        end
        sz    = sb.size();
        ev    = reset && (rv != 2'b00) && sz < 4;
        fire  = ev && mrdy;
        pop   = reset && rsp && sz > 0;
        erdy  = fire ? 2'(1 << w) : 2'b00;
        eresp = pop ? 2'(1 << sb[0].id) : 2'b00;
        check("req_rdy", 128'(req_rdy), 128'(erdy));
        check("memreq_val", 128'(memreq_val), 128'(ev));
        if (ev) check("memreq_msg", 128'(memreq_msg), 128'(req_word(w, tag)));
        check("resp_val", 128'(resp_val), 128'(eresp));
        if (pop) check("resp_msg", 128'(resp_msg), 128'(sb[0].msg));
        check("outstanding", 128'(outstanding), 128'(sz));
        check("protocol_err", 128'(protocol_err), 128'(exp_err));
        last_rdy  = req_rdy;
        last_resp = resp_val;
        if (pop) void'(sb.pop_front());
        if (fire) begin
            mem_q.push_back(rsp_of(memreq_msg));
            sb.push_back('{id: w, msg: rsp_of(req_word(w, tag))});
            exp_last = w;
        end
        if (reset && rsp && sz == 0) exp_err = 1'b1;
        exp_hold     = ev && !mrdy;
        exp_hold_idx = w;
        tag++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        sb.delete();
        exp_err      = 1'b0;
        exp_hold     = 1'b0;
        exp_hold_idx = 0;
        exp_last     = 1;
        cycle(2'b11, 1'b1, 1'b0);
        cycle(2'b11, 1'b1, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
`ifdef RISCVLONG_MEM_ARB_RR_EN
        grant_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        grant_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        order_seq   = '{2'b10, 2'b01, 2'b10};
        reset       = 1'b0;
        req_val     = 2'b00;
        req_msg     = '0;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        memresp_msg = '0;
        @(negedge clk);
        do_reset();

        // Single request, response three cycles later
        cycle(2'b01, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 1'b1);
        cycle(2'b00, 1'b1, 1'b0);

        // Contention with both requesters held
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(2'b11, 1'b1, 1'b0);
            check("grant_seq", 128'(last_rdy), 128'(grant_seq[k]));
        end

        // Full: no fire at DEPTH, even alongside a response; fires on the following cycle
        cycle(2'b11, 1'b1, 1'b0);
        cycle(2'b01, 1'b1, 1'b1);
        check("full_no_fire", 128'(last_rdy), 128'(2'b00));
        cycle(2'b01, 1'b1, 1'b0);
        check("fire_after_full", 128'(last_rdy), 128'(2'b01));
        repeat (4) cycle(2'b00, 1'b1, 1'b1);
        cycle(2'b00, 1'b1, 1'b0);

        // Stalled grant must hold when a higher-priority request appears
        cycle(2'b10, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b0);
        check("stall_hold", 128'(last_rdy), 128'(2'b10));
        cycle(2'b00, 1'b1, 1'b1);

        // In-order response routing
        cycle(2'b10, 1'b1, 1'b0);
        cycle(2'b01, 1'b1, 1'b0);
        cycle(2'b10, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(2'b00, 1'b1, 1'b1);
            check("order", 128'(last_resp), 128'(order_seq[k]));
        end

        // Spurious response sets a sticky error
        cycle(2'b00, 1'b1, 1'b1);
        cycle(2'b00, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 1'b0);

        // Reset with three outstanding, then a late response
        cycle(2'b01, 1'b1, 1'b0);
        cycle(2'b01, 1'b1, 1'b0);
        cycle(2'b01, 1'b1, 1'b0);
        check("pre_reset_outstanding", 128'(outstanding), 128'(3));
        do_reset();
        cycle(2'b00, 1'b1, 1'b1);
        cycle(2'b00, 1'b1, 1'b0);
        mem_q.delete();

        // Response in the same cycle as a fire from empty is dropped
        do_reset();
        cycle(2'b01, 1'b1, 1'b1);
        cycle(2'b00, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 1'b1);
        cycle(2'b00, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/riscvlong_mem_arbiter.md
RISCVLONG_MEM_ARBITER -- requirements
Module: riscvlong_mem_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requester ports (index 0 = imem, 1 = dmem in the core); legal range 2..8.
REQ-002 Parameter REQ_SZ, default 67, request message width (equals VC_MEM_REQ_MSG_SZ(32,32)); opaque, forwarded unmodified.
REQ-003 Parameter RESP_SZ, default 35, response message width (equals VC_MEM_RESP_MSG_SZ(32)); opaque, forwarded unmodified.
REQ-004 Parameter DEPTH, default 4, maximum outstanding requests; power of two, 2..16.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req_msg  in  NREQ*REQ_SZ  requester i message at bits [i*REQ_SZ +: REQ_SZ].
REQ-008 req_val  in  NREQ  per-requester request valid.
REQ-009 req_rdy  out  NREQ  per-requester request ready.
REQ-010 memreq_msg  out  REQ_SZ  granted request message.
REQ-011 memreq_val  out  1  downstream request valid.
REQ-012 memreq_rdy  in  1  downstream request ready.
REQ-013 memresp_msg  in  RESP_SZ  downstream response message.
REQ-014 memresp_val  in  1  downstream response valid; no ready, responses always accepted.
REQ-015 resp_msg  out  RESP_SZ  response message, broadcast to all requesters.
REQ-016 resp_val  out  NREQ  one-hot response valid, routed to the original requester.
REQ-017 outstanding  out  $clog2(DEPTH)+1  count of issued, unanswered requests.
REQ-018 protocol_err  out  1  sticky flag: response received with nothing outstanding.

Function
REQ-019 The block SHALL select one winner among asserted req_val bits each cycle, combinationally; memreq_msg SHALL equal the winner's message.
REQ-020 memreq_val SHALL be 1 iff any req_val is 1 and registered outstanding < DEPTH.
REQ-021 req_rdy[i] SHALL be 1 iff i is the winner, memreq_rdy=1 and outstanding < DEPTH; all other bits 0.
REQ-022 A fire (memreq_val & memreq_rdy) SHALL push the winner index into an in-order ID FIFO of DEPTH entries, with pointers wrapping modulo DEPTH.
REQ-023 When memresp_val=1 and outstanding>0, the FIFO head SHALL be popped, and in the same cycle resp_val SHALL be one-hot at the head index with resp_msg=memresp_msg.
REQ-024 When memresp_val=1 and outstanding=0, the response SHALL be dropped (resp_val=0) and protocol_err set to 1 from the next cycle until reset.
REQ-025 outstanding SHALL increment on push only, decrement on pop only, and stay unchanged on simultaneous push and pop.
REQ-026 Full gating SHALL use the registered count: at outstanding=DEPTH no push occurs even if a pop happens that cycle, so there is no combinational path from memresp_val to memreq_val or req_rdy.
REQ-027 A same-cycle response to a request fired while outstanding=0 SHALL be treated as REQ-024, because the downstream memory latency is at least 1 cycle.
REQ-028 The grant SHALL NOT change while memreq_val=1 and memreq_rdy=0 unless the winning req_val drops.

Reset
REQ-029 While reset=0, the block SHALL clear the FIFO pointers and set outstanding=0 and protocol_err=0, and SHALL force req_rdy=0, memreq_val=0 and resp_val=0.
REQ-030 Assertion mid-transaction SHALL discard all in-flight IDs; responses to those requests arriving after release SHALL follow REQ-024.

Configuration
REQ-031 With RISCVLONG_MEM_ARB_RR_EN defined, arbitration SHALL be round-robin:
  - A last-grant register is reset to NREQ-1.
  - Priority starts at (last+1) mod NREQ.
  - The register updates only on fire.
REQ-032 Without RISCVLONG_MEM_ARB_RR_EN, arbitration SHALL be fixed priority with lowest index winning, and the last-grant register SHALL be absent.

Verification
REQ-033 Single request: req_val=01, memreq_rdy=1, response 3 cycles later -> req_rdy=01 on the fire cycle; resp_val=01 on the response cycle; outstanding goes 0->1->0.
REQ-034 Contention, RR build: req_val=11 held, memreq_rdy=1 -> grant sequence 0,1,0,1; fixed build -> 0,0,0,0.
REQ-035 Full: DEPTH=4, 4 fires, no responses -> memreq_val=0 and req_rdy=00 with outstanding=4; response plus new request in the same cycle -> no fire that cycle, fire on the next.
REQ-036 Ordering: issue IDs 1,0,1, then three responses -> resp_val sequence 10,01,10 with messages in issue order.
REQ-037 Spurious response: memresp_val=1 at outstanding=0 -> resp_val=00 and protocol_err=1 from the next cycle and sticky.
REQ-038 Reset with outstanding=3 -> outstanding=0 and protocol_err=0; a late response after release sets protocol_err.
